lcd_write_scheduler: RTL
========================

LCD_WRITE_SCHEDULER -- requirements
Module: lcd_write_scheduler

Interface
REQ-001 Parameter CHAR_GAP, default 800, cycles between successive lcd_write pulses (80 us at 10 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, character queue depth; power of two.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 offers a character.
REQ-006 req0_data  input  8  requester 0 ASCII character.
REQ-007 req0_last  input  1  final character of requester 0 message.
REQ-008 req0_ready  output  1  requester 0 character accepted this cycle when valid is also high.
REQ-009 req1_valid, req1_data[7:0], req1_last, req1_ready: same as REQ-005..008 for requester 1.
REQ-010 lcd_ascii  output  8  character to the display controller ascii_data input.
REQ-011 lcd_write  output  1  one-cycle write strobe to the display controller write input.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  queued characters.
REQ-013 busy  output  1  high while locked, FIFO non-empty, or pacer not IDLE.

Function
REQ-014 Arbiter: when unlocked and any valid high, lock to one requester at the next edge; both valid -> requester holding round-robin priority wins.
REQ-015 Round-robin pointer: requester 0 has priority after reset; after each completed message, priority passes to the other requester.
REQ-016 reqN_ready = locked && owner==N && FIFO not full; combinational, never high for the non-owner.
REQ-017 Beat accepted when valid && ready; data pushed into FIFO that edge.
REQ-018 Accepted beat with last=1 clears lock at that edge; re-arbitration occurs the following cycle; earliest next accept is two cycles after the last beat.
REQ-019 Owner dropping valid mid-message keeps the lock; no timeout.
REQ-020 FIFO full: ready low; a pop in the same cycle does not raise ready that cycle.
REQ-021 Simultaneous push and pop when non-empty and non-full: fifo_count unchanged.
REQ-022 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count saturates neither above FIFO_DEPTH nor below 0.
REQ-023 Pacer states: IDLE, GAP.
REQ-024 IDLE with FIFO non-empty: pop head, register lcd_ascii<=head, lcd_write<=1, load gap counter, go to GAP.
REQ-025 GAP: lcd_write<=0, counter decrements; on terminal count return to IDLE so the next pulse, when data is waiting, rises exactly CHAR_GAP cycles after the previous.
REQ-026 lcd_write high exactly one cycle per character; lcd_ascii holds its last value between pulses.
REQ-027 Characters reach lcd_ascii in acceptance order; a locked message is never interleaved with the other requester.
REQ-028 Empty FIFO in IDLE: no pulse; stays IDLE.

Reset
REQ-029 During rst: lcd_write=0, lcd_ascii=8'h20, both ready=0, fifo_count=0, busy=0, unlocked, priority=requester 0, pacer IDLE, gap counter 0.
REQ-030 rst mid-message or mid-gap discards queued characters and the lock; first pulse after release no earlier than 2 cycles after first accepted beat.

Structure
REQ-031 Package lcd_pkg holds: pacer state enum, char_t (8-bit) typedef, CHAR_GAP default constant, space-character constant 8'h20.
REQ-032 Queue implemented as one sub-module char_fifo (synchronous, FIFO_DEPTH x 8, full/empty/count); arbiter and pacer stay in lcd_write_scheduler.

Verification (CHAR_GAP=4, FIFO_DEPTH=4)
REQ-033 req0 sends "HI" (last on 'I') alone -> lcd_write pulses with lcd_ascii 8'h48 then 8'h49, rising edges 4 cycles apart; busy falls after final gap.
REQ-034 req0 and req1 assert valid same cycle, each sending 2 chars "AB"/"CD" -> output order A,B,C,D; req1_ready never high during req0 message.
REQ-035 req1 holds 6-char message -> fifo_count reaches 4, req1_ready low while full, no character lost or duplicated.
REQ-036 Back-to-back messages from req0 then both valid -> req1 wins next arbitration (round-robin).
REQ-037 Assert rst for 1 cycle during GAP with 3 queued chars -> lcd_write 0, fifo_count 0, ready 0, no further pulses until new data.
REQ-038 req0 drops valid mid-message for 10 cycles while req1 valid -> req1_ready stays low; req0 resumes and completes first.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD write scheduler.
package lcd_pkg;

    typedef logic [7:0] char_t;

    typedef enum logic {
        PACER_IDLE,
        PACER_GAP
    } pacer_state_t;

    localparam int unsigned CHAR_GAP_DEFAULT = 800;
    localparam int unsigned GAP_CNT_W        = 16;
    localparam char_t       SPACE_CHAR       = 8'h20;

endpackage

// File: rtl/char_fifo.sv
// Synchronous character queue; read data is the current head, combinationally.
module char_fifo
    import lcd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  char_t                         push_data,
    input  logic                          pop,
    output char_t                         pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    char_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Two-requester message arbiter feeding a paced write strobe to a character LCD controller.
module lcd_write_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned CHAR_GAP   = CHAR_GAP_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic [7:0]                    req0_data,
    input  logic                          req0_last,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [7:0]                    req1_data,
    input  logic                          req1_last,
    output logic                          req1_ready,
    output logic [7:0]                    lcd_ascii,
    output logic                          lcd_write,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(CHAR_GAP - 2);

    logic                  locked;
    logic                  owner;
    logic                  prio;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  beat_last;
    char_t                 beat_data;
    char_t                 head;
    logic                  pop;
    pacer_state_t          state;
    pacer_state_t          state_next;
    logic [GAP_CNT_W-1:0]  gap_cnt;

    assign req0_ready = locked && !owner && !full;
    assign req1_ready = locked &&  owner && !full;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign beat_data  = owner ? req1_data : req0_data;
    assign beat_last  = owner ? req1_last : req0_last;
    assign busy       = locked || !empty || (state != PACER_IDLE);

    char_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (beat_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    // Lock is held until the owner's last beat; priority flips per completed message.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            owner  <= 1'b0;
            prio   <= 1'b0;
        end else if (locked) begin
            if (accept && beat_last) begin
                locked <= 1'b0;
                prio   <= ~owner;
            end
        end else if (req0_valid || req1_valid) begin
            locked <= 1'b1;
            owner  <= (req0_valid && req1_valid) ? prio : req1_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PACER_IDLE;
            gap_cnt   <= '0;
            lcd_write <= 1'b0;
            lcd_ascii <= SPACE_CHAR;
        end else begin
            state     <= state_next;
            lcd_write <= pop;
            if (pop) begin
                lcd_ascii <= head;
                gap_cnt   <= GAP_LOAD;
            end else if (state == PACER_GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // GAP lasts CHAR_GAP-1 cycles so the following IDLE pop lands exactly CHAR_GAP after the last pulse.
    always_comb begin
        state_next = state;
        case (state)
            PACER_IDLE: if (!empty)          state_next = PACER_GAP;
            PACER_GAP:  if (gap_cnt == '0)   state_next = PACER_IDLE;
            default:                         state_next = PACER_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        if (state == PACER_IDLE && !empty) begin
            pop = 1'b1;
        end
    end

endmodule
